// File: rtl/wb_timer.sv
// RISC-V style machine timer on a Wishbone classic slave port: 64-bit mtime with
// prescaler, 64-bit mtimecmp, level interrupt, and a shadowed MTIME_HI read path.
module wb_timer #(
  parameter int PRESCALE_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_CTRL     = 3'd4;
  localparam logic [2:0] ADR_STATUS   = 3'd5;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic [31:0]           r_shadow;
  logic [31:0]           r_dat;
  logic                  r_en;
  logic                  r_ie;
  logic [PRESCALE_W-1:0] r_presc;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_ack;
  logic                  r_irq;
  logic                  r_rst_d;

  logic                  w_accept;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_match;
  logic                  w_tick;
  logic [31:0]           w_wmask;
  logic [31:0]           w_ctrl;
  logic [31:0]           w_status;
  logic [31:0]           w_rdata;
  logic [31:0]           w_mtime_lo_wr;
  logic [31:0]           w_mtime_hi_wr;
  logic [31:0]           w_cmp_lo_wr;
  logic [31:0]           w_cmp_hi_wr;
  logic                  w_en_wr;
  logic                  w_ie_wr;
  logic [PRESCALE_W-1:0] w_presc_wr;
  logic [PRESCALE_W-1:0] w_pcnt_next;
  logic [63:0]           w_mtime_inc;

  // The first cycle after reset never accepts, so a strobe left over from
  // before reset is dropped rather than acknowledged.
  assign w_accept = wb_stb_i & ~r_ack & ~r_rst_d;
  assign w_wr     = w_accept & wb_we_i & (|wb_sel_i);
  assign w_rd     = w_accept & ~wb_we_i;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign w_wmask[8*gi +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  assign w_mtime_lo_wr = (r_mtime[31:0]     & ~w_wmask) | (wb_dat_i & w_wmask);
  assign w_mtime_hi_wr = (r_mtime[63:32]    & ~w_wmask) | (wb_dat_i & w_wmask);
  assign w_cmp_lo_wr   = (r_mtimecmp[31:0]  & ~w_wmask) | (wb_dat_i & w_wmask);
  assign w_cmp_hi_wr   = (r_mtimecmp[63:32] & ~w_wmask) | (wb_dat_i & w_wmask);

  assign w_en_wr = wb_sel_i[0] ? wb_dat_i[0] : r_en;
  assign w_ie_wr = wb_sel_i[0] ? wb_dat_i[1] : r_ie;

  generate
    for (genvar gi = 0; gi < PRESCALE_W; gi++) begin : g_presc_wr
      assign w_presc_wr[gi] = wb_sel_i[(8 + gi) / 8] ? wb_dat_i[8 + gi] : r_presc[gi];
    end
  endgenerate

  always_comb begin
    w_ctrl = '0;
    w_ctrl[0] = r_en;
    w_ctrl[1] = r_ie;
    w_ctrl[8 +: PRESCALE_W] = r_presc;
  end

  assign w_match  = (r_mtime >= r_mtimecmp);
  assign w_status = {31'd0, w_match};

  always_comb begin
    w_rdata = '0;
    case (wb_adr_i)
      ADR_MTIME_LO: w_rdata = r_mtime[31:0];
      ADR_MTIME_HI: w_rdata = r_shadow;
      ADR_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      ADR_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      ADR_CTRL:     w_rdata = w_ctrl;
      ADR_STATUS:   w_rdata = w_status;
      default:      w_rdata = '0;
    endcase
  end

  always_comb begin
    w_tick      = 1'b0;
    w_pcnt_next = r_pcnt;
    if (r_en) begin
      if (r_pcnt == r_presc) begin
        w_pcnt_next = '0;
        w_tick      = 1'b1;
      end else begin
        w_pcnt_next = r_pcnt + PRESCALE_W'(1);
      end
    end
  end

  assign w_mtime_inc = r_mtime + {63'd0, w_tick};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_irq   <= 1'b0;
      r_rst_d <= 1'b1;
    end else begin
      r_ack   <= w_accept;
      r_irq   <= r_ie & w_match;
      r_rst_d <= 1'b0;
      if (w_rd) begin
        r_dat <= w_rdata;
      end else if (w_accept) begin
        r_dat <= '0;
      end
    end
  end

  // A bus write to either mtime half wins over the tick; the other half keeps
  // its pre-increment value and no carry is applied in that cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mtime  <= '0;
      r_shadow <= '0;
    end else begin
      if (w_wr && wb_adr_i == ADR_MTIME_LO) begin
        r_mtime <= {r_mtime[63:32], w_mtime_lo_wr};
      end else if (w_wr && wb_adr_i == ADR_MTIME_HI) begin
        r_mtime <= {w_mtime_hi_wr, r_mtime[31:0]};
      end else begin
        r_mtime <= w_mtime_inc;
      end
      if (w_rd && wb_adr_i == ADR_MTIME_LO) begin
        r_shadow <= r_mtime[63:32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_mtimecmp <= '1;
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_presc    <= '0;
      r_pcnt     <= '0;
    end else begin
      if (w_wr && wb_adr_i == ADR_CMP_LO) begin
        r_mtimecmp[31:0] <= w_cmp_lo_wr;
      end
      if (w_wr && wb_adr_i == ADR_CMP_HI) begin
        r_mtimecmp[63:32] <= w_cmp_hi_wr;
      end
      if (w_wr && wb_adr_i == ADR_CTRL) begin
        r_en    <= w_en_wr;
        r_ie    <= w_ie_wr;
        r_presc <= w_presc_wr;
        r_pcnt  <= '0;
      end else begin
        r_pcnt  <= w_pcnt_next;
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule
